// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// prog_loader_if : byte-stream receive handshake plus instruction-memory write
//                  port of the program loader.
// Revision 1.0
// ============================================================================
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader : loads a MAGIC/CNT-framed byte image into instruction memory as
//               big-endian 16-bit words; holds the CPU in reset while loading.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
module prog_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_HDR_MAGIC  = 4'd1;
  localparam logic [3:0] S_HDR_CNT_HI = 4'd2;
  localparam logic [3:0] S_HDR_CNT_LO = 4'd3;
  localparam logic [3:0] S_WORD_HI    = 4'd4;
  localparam logic [3:0] S_WORD_LO    = 4'd5;
  localparam logic [3:0] S_DONE       = 4'd6;
  localparam logic [3:0] S_ERR        = 4'd7;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK        = 4'd8;
  localparam logic [3:0] S_TAIL       = S_CHK;
`else
  localparam logic [3:0] S_TAIL       = S_DONE;
`endif

  logic [3:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              active_q, active_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              w_hs;
  logic [15:0]       w_cnt;
  logic [CNT_W-1:0]  w_words_inc;

  assign w_hs        = bus.rx_valid & active_q;
  assign w_cnt       = {hi_q, bus.rx_data};
  assign w_words_inc = words_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    // The address advances in the cycle after its write strobe.
    mem_addr_d  = mem_we_q ? (mem_addr_q + ADDR_W'(1)) : mem_addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_MAGIC;
          mem_addr_d = '0;
          words_d    = '0;
          cnt_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d      = 8'h00;
`endif
        end
      end
      S_HDR_MAGIC: begin
        if (w_hs) state_d = (bus.rx_data == MAGIC) ? S_HDR_CNT_HI : S_ERR;
      end
      S_HDR_CNT_HI: begin
        if (w_hs) begin
          hi_d    = bus.rx_data;
          state_d = S_HDR_CNT_LO;
        end
      end
      S_HDR_CNT_LO: begin
        if (w_hs) begin
          cnt_d = w_cnt[CNT_W-1:0];
          if (32'(w_cnt) > MAX_WORDS) state_d = S_ERR;
          else if (w_cnt == 16'd0)    state_d = S_TAIL;
          else                        state_d = S_WORD_HI;
        end
      end
      S_WORD_HI: begin
        if (w_hs) begin
          hi_d    = bus.rx_data;
          state_d = S_WORD_LO;
        end
      end
      S_WORD_LO: begin
        if (w_hs) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = {hi_q, bus.rx_data};
          words_d     = w_words_inc;
          state_d     = (w_words_inc == cnt_q) ? S_TAIL : S_WORD_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_hs) state_d = (bus.rx_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef PROG_LOADER_CHECKSUM_EN
    if (w_hs && (state_q == S_HDR_CNT_HI || state_q == S_HDR_CNT_LO ||
                 state_q == S_WORD_HI    || state_q == S_WORD_LO))
      chk_d = chk_q ^ bus.rx_data;
`endif

    // Status outputs are registered from the next state so they are glitch-free.
    active_d   = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    cpu_hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hi_q        <= 8'h00;
      cnt_q       <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      active_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      active_q    <= active_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign bus.rx_ready  = active_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = active_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_prog_loader : directed bench for prog_loader; an image-level model predicts
//                  the write stream and final status, a scoreboard checks it.
// Revision 1.0
// ============================================================================
module tb_prog_loader;

  typedef logic [7:0] q8_t [$];

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, busy, done, err;

  int checks = 0;
  int errors = 0;

  prog_loader_if #(.ADDR_W(10)) bus ();

  prog_loader #(.ADDR_W(10), .MAGIC(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  logic [25:0] exp_q [$];
  logic [25:0] exp_w;
  logic [15:0] dut_mem [1024];
  int          we_count = 0;
  logic [9:0]  last_addr = 10'h000;
  bit          exp_done, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every write strobe must match the next predicted {addr,data}.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (bus.mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
            errors++;
            $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                     bus.mem_addr, bus.mem_wdata, exp_w[25:16], exp_w[15:0]);
          end
        end
        dut_mem[bus.mem_addr] = bus.mem_wdata;
        we_count++;
        last_addr = bus.mem_addr;
      end
      check("ready_eq_busy", 32'(bus.rx_ready), 32'(busy));
      if (busy === 1'b1) check("hold_while_busy", 32'(cpu_hold), 32'd1);
    end
  end

  // Image-level model: parse the byte image by the format rules.
  task automatic model_load(input q8_t img);
    int cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (img[0] != 8'hA5) return;
    cnt = int'({img[1], img[2]});
    if (cnt > 1024) return;
`ifdef PROG_LOADER_CHECKSUM_EN
    x = img[1] ^ img[2];
`endif
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({10'(i), img[3 + 2*i], img[4 + 2*i]});
`ifdef PROG_LOADER_CHECKSUM_EN
      x = x ^ img[3 + 2*i] ^ img[4 + 2*i];
`endif
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (img[3 + 2*cnt] != x) return;
`endif
    exp_done = 1'b1;
    exp_err  = 1'b0;
  endtask

  function automatic q8_t sealed(input q8_t img);
    q8_t r = img;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (img[i]) if (i > 0) x = x ^ img[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t = 0;
    bus.rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (poke && g == 0) begin
        check("busy_at_poke", 32'(busy), 32'd1);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_no_stall", 32'(t), 32'd0);
    if (bus.rx_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input q8_t img, input bit gapped);
    model_load(img);
    pulse_start();
    foreach (img[i])
      send_byte(img[i], gapped ? int'($urandom_range(1, 3)) : 0,
                gapped && (i > 0) && (i < img.size() - 1));
    repeat (3) @(posedge clk);
    #1;
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("cpu_hold", 32'(cpu_hold), 32'(exp_err));
    check("busy_end", 32'(busy), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    q8_t        img;
    q8_t        t1;
    int         w0;
    logic [15:0] snap [8];

    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word image.
    t1 = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h01, 8'h22, 8'h03};
    t1 = sealed(t1);
    w0 = we_count;
    run_load(t1, 1'b0);
    check("t1_mem0", 32'(dut_mem[0]), 32'h1001);
    check("t1_mem1", 32'(dut_mem[1]), 32'h2203);
    check("t1_pulses", 32'(we_count - w0), 32'd2);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_addr_after", 32'(bus.mem_addr), 32'd2);

    // Bad magic, then recovery with a good image.
    img = {8'h5A};
    w0 = we_count;
    run_load(img, 1'b0);
    check("magic_err", 32'(err), 32'd1);
    check("magic_hold", 32'(cpu_hold), 32'd1);
    check("magic_pulses", 32'(we_count - w0), 32'd0);
    run_load(t1, 1'b0);
    check("recover_done", 32'(done), 32'd1);
    check("recover_err", 32'(err), 32'd0);
    check("recover_hold", 32'(cpu_hold), 32'd0);

    // Count boundaries: 1025 rejected, 0 completes without writes.
    img = {8'hA5, 8'h04, 8'h01};
    run_load(img, 1'b0);
    check("cnt1025_err", 32'(err), 32'd1);
    img = {8'hA5, 8'h00, 8'h00};
    img = sealed(img);
    w0 = we_count;
    run_load(img, 1'b0);
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_pulses", 32'(we_count - w0), 32'd0);

    // Full 1024-word image, data equals address.
    img = {8'hA5, 8'h04, 8'h00};
    for (int a = 0; a < 1024; a++) begin
      img.push_back(8'(a >> 8));
      img.push_back(8'(a));
    end
    img = sealed(img);
    w0 = we_count;
    run_load(img, 1'b0);
    check("full_pulses", 32'(we_count - w0), 32'd1024);
    check("full_last_addr", 32'(last_addr), 32'h3FF);
    check("full_last_data", 32'(dut_mem[1023]), 32'h03FF);
    check("full_addr_wrap", 32'(bus.mem_addr), 32'd0);
    check("full_done", 32'(done), 32'd1);

    // Same image back-to-back and gapped with start pokes mid-load.
    img = {8'hA5, 8'h00, 8'h08};
    for (int i = 0; i < 8; i++) begin
      img.push_back(8'(192 + i));
      img.push_back(8'(60 ^ (i * 5)));
    end
    img = sealed(img);
    run_load(img, 1'b0);
    for (int i = 0; i < 8; i++) snap[i] = dut_mem[i];
    for (int i = 0; i < 8; i++) dut_mem[i] = 16'h0000;
    run_load(img, 1'b1);
    for (int i = 0; i < 8; i++) check("gapped_mem", 32'(dut_mem[i]), 32'(snap[i]));

`ifdef PROG_LOADER_CHECKSUM_EN
    img = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_load(img, 1'b0);
    check("chk_ok_done", 32'(done), 32'd1);
    img = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    run_load(img, 1'b0);
    check("chk_bad_err", 32'(err), 32'd1);
    check("chk_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    // Reset during the write strobe of the first word.
    pulse_start();
    img = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    foreach (img[i]) send_byte(img[i], 0, 1'b0);
    check("pre_reset_we", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(t1, 1'b0);
    check("post_reset_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
